sram_sdp_clr: RTL
=================

# sram_sdp_clr

Parametrised simple-dual-port SRAM with per-lane write mask, a self-clearing initialisation engine, and optional read-during-write bypass. It is the next-generation behavioural macro behind cache tag and data arrays. After reset, or on a flush request, it writes a fixed init value to every entry, so valid bits start cleared without help from the cache controller. Port A is read-only, port B is write-only, and both share one clock.

## Interface
Parameters:
- AW, 5, address width; DEPTH = 2**AW entries
- DW, 7, data width
- BW, 7, write-lane width; DW % BW == 0; NL = DW/BW lanes
- INIT, 0, DW-bit value written to every entry by the clear engine

Ports:
- CLK  in  1  sole clock, rising edge
- RSTN  in  1  asynchronous active-low reset
- CENA  in  1  read enable, active-low
- AA  in  AW  read address
- QA  out  DW  read data, registered
- CENB  in  1  write enable, active-low
- WENB  in  NL  per-lane write enable, active-low
- AB  in  AW  write address
- DB  in  DW  write data
- CLR  in  1  flush request, active-high, single-cycle pulse
- BUSY  out  1  clear engine running; port A and port B are ignored while high

## Operation
- Reset values: QA = 0, BUSY = 1, state = CLEAR, clear counter = 0. Array contents are undefined until the clear completes.
- States:
  - CLEAR: each edge writes INIT to address cnt, all lanes, then increments cnt. When cnt == DEPTH-1 the write completes, cnt wraps to 0 and the state moves to IDLE.
  - IDLE: normal access. CLR == 1 at an edge moves the state to CLEAR with cnt = 0.
- CLR while BUSY is ignored and does not restart the count.
- RSTN asserted mid-clear: immediate return to CLEAR with cnt = 0. The full clear reruns after release.
- Read, IDLE only: CENA low at edge N loads QA from AA. CENA high holds QA. While BUSY, QA holds its value.
- Write, IDLE only: CENB low at edge N writes DB lane i to AB when WENB[i] is low. Lanes with WENB[i] high are unchanged. CENB low with all WENB high writes nothing.
- Read and write on the same edge at different addresses: both are performed independently.
- Read and write on the same edge at the same address: result is set by the configuration below.
- CLR together with port accesses at the same edge (state IDLE): the accesses complete, including the QA update. The clear then overwrites the array.
- No arithmetic beyond the AW-bit counter. The counter wraps naturally at DEPTH.

## Timing
- Read latency is 1 cycle: QA is valid after the edge that samples CENA low.
- Write is visible to a read issued at the following edge.
- Clear duration is DEPTH edges. After RSTN release, the first edge writes address 0. BUSY falls after edge DEPTH, which writes address DEPTH-1.
- CLR sampled at edge N: BUSY is high after edge N. Edges N+1 through N+DEPTH write addresses 0 through DEPTH-1. BUSY is low after edge N+DEPTH.
- BUSY is registered, with no combinational path from CLR to BUSY.

## Configuration
- SRAM_BYPASS_EN defined: for a same-address read and write on one edge, QA lanes with WENB[i] low take DB lane i. The other lanes take the stored data. This is write-first behaviour.
- SRAM_BYPASS_EN undefined: QA returns the pre-write contents, which is read-first behaviour. The new data is visible from the next read.
- Port timing and latency are identical in both builds.

## Structure
- Package sram_pkg holds:
  - the state typedef (CLEAR, IDLE)
  - a lane-merge function (old, new, active-low mask, BW)
  - shared lane-count helper constants
- Sub-module sram_sdp_core contains the storage array, the registered read port, the masked write port and the bypass mux.
- sram_sdp_clr wraps sram_sdp_core with the clear FSM and counter. It muxes port B between the clear engine and the user.

## Test plan
- Reset clear: release RSTN with AW=5, INIT=0x55, then wait for BUSY to fall. BUSY must fall exactly 32 edges after release, and reads of addresses 0..31 must all return 0x55.
- Masked write: use DW=32, BW=8. Write 0xAABBCCDD to address 3 with WENB=4'b1010, then read address 3. QA must equal INIT with lanes 0 and 2 replaced: INIT=0 gives 0x00BB00DD.
- Collision: same edge, write 0x12345678 (all lanes) and read address 7, which holds 0. With SRAM_BYPASS_EN, QA must be 0x12345678. Without it, QA must be 0, and the next read must return 0x12345678.
- Flush: after filling all entries, pulse CLR together with a read. The read data must be correct. BUSY must be high for exactly 32 cycles. A second CLR mid-clear must not extend BUSY. All entries must read INIT afterwards.
- Reset mid-clear: assert RSTN at cnt=10. BUSY must stay 1 and QA must be 0. After release, BUSY must be high for a full 32 edges.
- Accesses while BUSY: drive writes and reads during the clear. The array must contain only INIT afterwards, and QA must not change while BUSY is high.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared types and helpers for the sram_sdp_clr macro family.
// Optional feature macro used by this family: SRAM_BYPASS_EN (write-first collision bypass).
package sram_pkg;

    // Upper bounds for the generic lane-merge helper; callers zero-extend into these.
    localparam int unsigned MAX_DW = 256;
    localparam int unsigned MAX_NL = MAX_DW;
    localparam int unsigned LDW    = $clog2(MAX_DW);
    localparam int unsigned LNW    = $clog2(MAX_NL);

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    // Number of write lanes for a given data and lane width.
    function automatic int unsigned num_lanes(input int unsigned dw, input int unsigned bw);
        return dw / bw;
    endfunction

    // Replace the lanes of old_data whose active-low enable is low with new_data.
    function automatic logic [MAX_DW-1:0] lane_merge(
        input logic [MAX_DW-1:0] old_data,
        input logic [MAX_DW-1:0] new_data,
        input logic [MAX_NL-1:0] wen_n,
        input int unsigned       bw
    );
        logic [MAX_DW-1:0] res;
        res = old_data;
        for (int unsigned i = 0; i < MAX_DW; i++) begin
            if (!wen_n[LNW'(i / bw)]) begin
                res[LDW'(i)] = new_data[LDW'(i)];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sram_sdp_core.sv
// Storage array with a registered read port, lane-masked write port and
// optional write-first bypass (SRAM_BYPASS_EN) for same-address collisions.
module sram_sdp_core
    import sram_pkg::*;
#(
    parameter  int unsigned AW = 5,
    parameter  int unsigned DW = 7,
    parameter  int unsigned BW = 7,
    localparam int unsigned NL = num_lanes(DW, BW)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    input  logic          wr_en,
    input  logic [NL-1:0] wr_wen_n,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data
);

    localparam int unsigned DEPTH = 2 ** AW;

    logic [DW-1:0]     mem [DEPTH];
    logic [MAX_NL-1:0] wen_ext_c;
    logic [DW-1:0]     wr_merged_c;
    logic [DW-1:0]     rd_word_c;

    assign wen_ext_c = {{(MAX_NL - NL){1'b1}}, wr_wen_n};

    // Word to store: enabled lanes from wr_data, the rest from the current entry.
    always_comb begin
        wr_merged_c = DW'(lane_merge(MAX_DW'(mem[wr_addr]), MAX_DW'(wr_data), wen_ext_c, BW));
    end

    // Word presented to the read register, with collision handling.
    always_comb begin
        rd_word_c = mem[rd_addr];
`ifdef SRAM_BYPASS_EN
        if (wr_en && (wr_addr == rd_addr)) begin
            rd_word_c = wr_merged_c;
        end
`else
`endif
    end

    // Masked write into the array.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_merged_c;
        end
    end

    // Registered read port; holds when not enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= rd_word_c;
        end
    end

endmodule

// File: rtl/sram_sdp_clr.sv
// Simple-dual-port SRAM with self-clearing init engine after reset and on CLR.
// Define SRAM_BYPASS_EN for write-first same-address behaviour (read-first otherwise).
module sram_sdp_clr
    import sram_pkg::*;
#(
    parameter  int unsigned   AW   = 5,
    parameter  int unsigned   DW   = 7,
    parameter  int unsigned   BW   = 7,
    parameter  logic [DW-1:0] INIT = '0,
    localparam int unsigned   NL   = num_lanes(DW, BW)
) (
    input  logic          CLK,
    input  logic          RSTN,
    input  logic          CENA,
    input  logic [AW-1:0] AA,
    output logic [DW-1:0] QA,
    input  logic          CENB,
    input  logic [NL-1:0] WENB,
    input  logic [AW-1:0] AB,
    input  logic [DW-1:0] DB,
    input  logic          CLR,
    output logic          BUSY
);

    localparam logic [AW-1:0] CNT_LAST = '1;

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          busy_d;

    logic          core_rd_en_c;
    logic          core_wr_en_c;
    logic [NL-1:0] core_wen_n_c;
    logic [AW-1:0] core_wr_addr_c;
    logic [DW-1:0] core_wr_data_c;

    // State, clear counter and BUSY registers.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            BUSY    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            BUSY    <= busy_d;
        end
    end

    // Next state and port muxing between the clear engine and the user.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        core_rd_en_c   = 1'b0;
        core_wr_en_c   = 1'b0;
        core_wen_n_c   = '1;
        core_wr_addr_c = AB;
        core_wr_data_c = DB;
        case (state_q)
            CLEAR: begin
                core_wr_en_c   = 1'b1;
                core_wen_n_c   = '0;
                core_wr_addr_c = cnt_q;
                core_wr_data_c = INIT;
                cnt_d          = cnt_q + AW'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                core_rd_en_c = !CENA;
                core_wr_en_c = !CENB;
                core_wen_n_c = WENB;
                if (CLR) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
        endcase
        busy_d = (state_d == CLEAR);
    end

    sram_sdp_core #(
        .AW(AW),
        .DW(DW),
        .BW(BW)
    ) u_core (
        .clk      (CLK),
        .rst_n    (RSTN),
        .rd_en    (core_rd_en_c),
        .rd_addr  (AA),
        .rd_data  (QA),
        .wr_en    (core_wr_en_c),
        .wr_wen_n (core_wen_n_c),
        .wr_addr  (core_wr_addr_c),
        .wr_data  (core_wr_data_c)
    );

endmodule
